// File: rtl/stepper_pkg.sv
// Shared types and default sizing for the stepper move sequencer.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RUN,
    HOLD,
    DONE
  } state_e;

  localparam logic DIR_CW  = 1'b0;  // position decrements
  localparam logic DIR_CCW = 1'b1;  // position increments

  localparam int CNT_W_DEF      = 16;
  localparam int PER_W_DEF      = 20;
  localparam int POS_W_DEF      = 24;
  localparam int MIN_PERIOD_DEF = 4;
  localparam int SETTLE_CYC_DEF = 50000;
  localparam int HOLD_CYC_DEF   = 50000;

endpackage

// File: rtl/stepper_move_ctrl_if.sv
// Move-command handshake between the control FSM (master) and a stepper move sequencer (slave).
interface stepper_move_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [PER_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/step_period_timer.sv
// Step interval down-counter; zero flags the step cycle. With STEPPER_RAMP_EN defined it also
// owns the current period and the symmetric accelerate/decelerate ramp.
module step_period_timer
  import stepper_pkg::*;
#(
  parameter int PER_W = PER_W_DEF
`ifdef STEPPER_RAMP_EN
  ,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int START_PERIOD = 4096,
  parameter int RAMP_DEC     = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [PER_W-1:0] period,
`ifdef STEPPER_RAMP_EN
  input  logic [CNT_W-1:0] steps_left,
`endif
  output logic             zero
);

  logic [PER_W-1:0] cnt_q;
  logic [PER_W-1:0] reload;

  assign zero = run && (cnt_q == '0);

`ifdef STEPPER_RAMP_EN
  logic [PER_W-1:0] cur_q;
  logic [PER_W-1:0] ceil_p;
  logic [PER_W-1:0] next_p;
  logic [CNT_W-1:0] acc_q;
  logic             decel;
  logic             accel_step;

  // Decelerate once the steps still to go after this pulse fit in the accelerating steps taken.
  always_comb begin
    ceil_p     = (period > PER_W'(START_PERIOD)) ? period : PER_W'(START_PERIOD);
    decel      = (steps_left - CNT_W'(1)) <= acc_q;
    accel_step = 1'b0;
    if (decel) begin
      next_p = ((ceil_p - cur_q) > PER_W'(RAMP_DEC)) ? cur_q + PER_W'(RAMP_DEC) : ceil_p;
    end else begin
      next_p     = ((cur_q - period) > PER_W'(RAMP_DEC)) ? cur_q - PER_W'(RAMP_DEC) : period;
      accel_step = (cur_q != period);
    end
    reload = run ? next_p : ceil_p;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      acc_q <= '0;
    end else if (!run) begin
      cur_q <= ceil_p;
      acc_q <= '0;
    end else if (zero) begin
      cur_q <= next_p;
      if (accel_step) acc_q <= acc_q + CNT_W'(1);
    end
  end
`else
  assign reload = period;
`endif

  // NOTE: registers use non-blocking <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run || zero) begin
      cnt_q <= reload - PER_W'(1);
    end else begin
      cnt_q <= cnt_q - PER_W'(1);
    end
  end

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper move sequencer: accepts a move, settles, paces step pulses, holds, then reports done.
// Optional acceleration ramp in the period timer is enabled by defining STEPPER_RAMP_EN.
module stepper_move_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PER_W      = PER_W_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF
`ifdef STEPPER_RAMP_EN
  ,
  parameter int START_PERIOD = 4096,
  parameter int RAMP_DEC     = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  stepper_move_ctrl_if.slave  cmd,
  input  logic                abort,
  output logic                step_pulse,
  output logic                dir,
  output logic                energize,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [POS_W-1:0]    position,
  output logic [CNT_W-1:0]    steps_left
);

  localparam int WAIT_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  state_e           state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [PER_W-1:0] period_q;
  logic [CNT_W-1:0] steps_q;
  logic [POS_W-1:0] pos_q;
  logic             dir_q;
  logic             abort_q;
  logic             accept;
  logic             run;
  logic             pulse;
  logic             abortable;
  logic [PER_W-1:0] period_clamped;

  assign accept         = (state_q == IDLE) && cmd.cmd_valid;
  assign run            = (state_q == RUN);
  assign abortable      = (state_q == SETTLE) || (state_q == RUN);
  assign period_clamped = (cmd.cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd.cmd_period;

  step_period_timer #(
    .PER_W        (PER_W)
`ifdef STEPPER_RAMP_EN
    ,
    .CNT_W        (CNT_W),
    .START_PERIOD (START_PERIOD),
    .RAMP_DEC     (RAMP_DEC)
`endif
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .period     (period_q),
`ifdef STEPPER_RAMP_EN
    .steps_left (steps_q),
`endif
    .zero       (pulse)
  );

  // NOTE: state_d gets its default first so no branch leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd.cmd_valid) state_d = (cmd.cmd_steps == '0) ? DONE : SETTLE;
      SETTLE: begin
        if (abort) state_d = HOLD;
        else if (wait_q == WAIT_W'(SETTLE_CYC - 1)) state_d = RUN;
      end
      RUN:     if (abort || (pulse && steps_q == CNT_W'(1))) state_d = HOLD;
      HOLD:    if (wait_q == WAIT_W'(HOLD_CYC - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      period_q <= '0;
      steps_q  <= '0;
      pos_q    <= '0;
      dir_q    <= DIR_CW;
      abort_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Dwell counter restarts on every state change, so SETTLE/HOLD each count from zero.
      wait_q  <= (state_d != state_q) ? '0 : wait_q + WAIT_W'(1);
      if (accept) begin
        steps_q  <= cmd.cmd_steps;
        dir_q    <= cmd.cmd_dir;
        period_q <= period_clamped;
        abort_q  <= 1'b0;
      end
      if (abortable && abort) abort_q <= 1'b1;
      // A pulse coinciding with abort is still issued, so it is always counted here.
      if (pulse) begin
        steps_q <= steps_q - CNT_W'(1);
        pos_q   <= (dir_q == DIR_CCW) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign energize      = (state_q == SETTLE) || (state_q == RUN) || (state_q == HOLD);
  assign done          = (state_q == DONE);
  assign aborted       = done && abort_q;
  assign step_pulse    = pulse;
  assign dir           = dir_q;
  assign position      = pos_q;
  assign steps_left    = steps_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl with short settle/hold windows; ramp build runs the ramp vector.
module tb_stepper_move_ctrl;
  import stepper_pkg::*;

  localparam int CNT_W  = 16;
  localparam int PER_W  = 20;
  localparam int POS_W  = 24;
  localparam int SETTLE = 4;
  localparam int HOLD   = 8;
  localparam int MINP   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             abort = 1'b0;
  logic             step_pulse, dir, energize, busy, done, aborted;
  logic [POS_W-1:0] position;
  logic [CNT_W-1:0] steps_left;

  stepper_move_ctrl_if #(.CNT_W(CNT_W), .PER_W(PER_W)) cmd_if ();

  stepper_move_ctrl #(
    .CNT_W      (CNT_W),
    .PER_W      (PER_W),
    .POS_W      (POS_W),
    .MIN_PERIOD (MINP),
    .SETTLE_CYC (SETTLE),
    .HOLD_CYC   (HOLD)
`ifdef STEPPER_RAMP_EN
    ,
    .START_PERIOD (40),
    .RAMP_DEC     (10)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .abort      (abort),
    .step_pulse (step_pulse),
    .dir        (dir),
    .energize   (energize),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .position   (position),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int pulse_cyc[$];
  int pulse_left[$];
  int done_cyc, done_cnt, en_first, en_last, acc_cyc, abort_cyc;
  bit en_seen, done_abt, done_en;

  // Event log sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (step_pulse) begin
      pulse_cyc.push_back(cyc);
      pulse_left.push_back(int'(steps_left));
    end
    if (energize) begin
      if (!en_seen) en_first = cyc;
      en_seen = 1'b1;
      en_last = cyc;
    end
    if (done) begin
      done_cyc = cyc;
      done_abt = aborted;
      done_en  = energize;
      done_cnt++;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_left.delete();
    done_cnt = 0;
    done_cyc = -1;
    en_seen  = 1'b0;
    en_first = -1;
    en_last  = -1;
    done_abt = 1'b0;
    done_en  = 1'b0;
  endtask

  // Offer one command for exactly one cycle (the DUT is idle, so it is taken that cycle).
  task automatic send(input int steps, input bit d, input int per);
    clear_log();
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_steps  = CNT_W'(steps);
    cmd_if.cmd_dir    = d;
    cmd_if.cmd_period = PER_W'(per);
    acc_cyc = cyc;
    tick();
  endtask

  // Wait for done with a cycle budget; optionally raise abort once abort_at pulses have been seen.
  task automatic wait_done(input string tag, input int abort_at);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (abort_at > 0 && !abort && pulse_cyc.size() == abort_at) begin
        abort     = 1'b1;
        abort_cyc = cyc;
      end
      tick();
      n++;
    end
    abort = 1'b0;
    check({tag, "_done_once"}, done_cnt, 1);
  endtask

  function automatic longint spos();
    return longint'($signed(position));
  endfunction

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_steps  = '0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_period = '0;
    clear_log();
    do_reset();

    // Reset state
    check("rst_ready",    cmd_if.cmd_ready, 1);
    check("rst_busy",     busy, 0);
    check("rst_energize", energize, 0);
    check("rst_pulse",    step_pulse, 0);
    check("rst_done",     done, 0);
    check("rst_aborted",  aborted, 0);
    check("rst_dir",      dir, 0);
    check("rst_pos",      spos(), 0);
    check("rst_left",     steps_left, 0);

`ifndef STEPPER_RAMP_EN
    // 5 steps CCW, period 10: first pulse SETTLE+10 after accept, 10 apart, done after 8 HOLD cycles.
    send(5, 1'b1, 10);
    cmd_if.cmd_valid = 1'b0;
    wait_done("s1", 0);
    check("s1_en_first", en_first - acc_cyc, 1);
    check("s1_npulse",   pulse_cyc.size(), 5);
    if (pulse_cyc.size() == 5) begin
      check("s1_first", pulse_cyc[0] - acc_cyc, SETTLE + 10);
      for (int i = 1; i < 5; i++) check("s1_gap", pulse_cyc[i] - pulse_cyc[i-1], 10);
      check("s1_done_at", done_cyc - pulse_cyc[4], HOLD + 1);
    end
    check("s1_en_last", en_last, done_cyc - 1);
    check("s1_done_en", done_en, 0);
    check("s1_aborted", done_abt, 0);
    check("s1_pos",     spos(), 5);
    check("s1_left",    steps_left, 0);

    // 3 steps CW with period 1: clamped to MIN_PERIOD.
    do_reset();
    send(3, 1'b0, 1);
    cmd_if.cmd_valid = 1'b0;
    wait_done("s2", 0);
    check("s2_npulse", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      check("s2_first", pulse_cyc[0] - acc_cyc, SETTLE + MINP);
      check("s2_gap1",  pulse_cyc[1] - pulse_cyc[0], MINP);
      check("s2_gap2",  pulse_cyc[2] - pulse_cyc[1], MINP);
      check("s2_left0", pulse_left[0], 3);
      check("s2_left1", pulse_left[1], 2);
      check("s2_left2", pulse_left[2], 1);
    end
    check("s2_left_end", steps_left, 0);
    check("s2_pos",      spos(), -3);

    // Zero-step move straight after (position stays at -3): done next cycle, never energised.
    send(0, 1'b1, 10);
    cmd_if.cmd_valid = 1'b0;
    wait_done("s3", 0);
    check("s3_done_at", done_cyc - acc_cyc, 1);
    check("s3_energize", en_seen, 0);
    check("s3_npulse",   pulse_cyc.size(), 0);
    check("s3_pos",      spos(), -3);

    // Abort after the 7th pulse of a 100-step move.
    do_reset();
    send(100, 1'b1, 10);
    cmd_if.cmd_valid = 1'b0;
    wait_done("s4", 7);
    check("s4_npulse",  pulse_cyc.size(), 7);
    check("s4_hold",    done_cyc - abort_cyc - 1, HOLD);
    check("s4_en_last", en_last, done_cyc - 1);
    check("s4_aborted", done_abt, 1);
    check("s4_pos",     spos(), 7);
    check("s4_left",    steps_left, 93);

    // cmd_valid held high with new fields during a move, then reset mid-RUN.
    do_reset();
    send(2, 1'b1, 4);
    cmd_if.cmd_steps  = CNT_W'(3);
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_period = PER_W'(6);
    wait_done("s5", 0);
    check("s5_npulse", pulse_cyc.size(), 2);
    check("s5_pos",    spos(), 2);
    check("s5_ready",  cmd_if.cmd_ready, 1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("s5_busy2",  busy, 1);
    check("s5_left2",  steps_left, 3);
    check("s5_dir2",   dir, 0);
    begin
      int n;
      n = 0;
      while (pulse_cyc.size() < 3 && n < 200) begin
        tick();
        n++;
      end
    end
    check("s5_b_npulse", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) check("s5_b_first", pulse_cyc[2] - done_cyc, 1 + SETTLE + 6);
    rst = 1'b1;
    tick();
    check("s5_rst_busy",  busy, 0);
    check("s5_rst_en",    energize, 0);
    check("s5_rst_pos",   spos(), 0);
    check("s5_rst_left",  steps_left, 0);
    check("s5_rst_dir",   dir, 0);
    check("s5_rst_ready", cmd_if.cmd_ready, 1);
    rst = 1'b0;
    repeat (20) tick();
    check("s5_no_done",   done_cnt, 1);
    check("s5_no_pulse",  pulse_cyc.size(), 3);
`else
    // Ramp: START 40, DEC 10, period 10, 8 steps.
    begin
      int exp_iv[8] = '{40, 30, 20, 10, 10, 20, 30, 40};
      send(8, 1'b1, 10);
      cmd_if.cmd_valid = 1'b0;
      wait_done("r1", 0);
      check("r1_npulse", pulse_cyc.size(), 8);
      if (pulse_cyc.size() == 8) begin
        check("r1_iv0", pulse_cyc[0] - acc_cyc - SETTLE, exp_iv[0]);
        for (int i = 1; i < 8; i++) check("r1_iv", pulse_cyc[i] - pulse_cyc[i-1], exp_iv[i]);
        check("r1_done_at", done_cyc - pulse_cyc[7], HOLD + 1);
      end
      check("r1_pos",     spos(), 8);
      check("r1_aborted", done_abt, 0);
    end

    send(0, 1'b0, 10);
    cmd_if.cmd_valid = 1'b0;
    wait_done("r2", 0);
    check("r2_done_at",  done_cyc - acc_cyc, 1);
    check("r2_energize", en_seen, 0);
    check("r2_pos",      spos(), 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
